// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared widths, FSM state encoding, queue entry layout and the fetch address check
// for the instruction fetch sequencer.
package imem_fetch_sequencer_pkg;

  localparam int ADDR_W     = 64;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } q_entry_t;

  // A carry out of the 64-bit increment counts as running past the image.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                    input logic              carry,
                                    input logic [ADDR_W-1:0] limit);
    return carry || (addr >= limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/imem_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the instruction memory, the branch unit and decode.
// Handshake: decode takes the head entry on every rising edge where inst_valid && inst_ready;
// while inst_valid is high and inst_ready is low, inst and inst_pc stay unchanged.
interface imem_fetch_sequencer_if;
  import imem_fetch_sequencer_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              fetch_fault;

  modport master (
    output imem_addr, inst_valid, inst, inst_pc, fetch_fault,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, inst_valid, inst, inst_pc, fetch_fault,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/imem_fetch_sequencer_fetch_queue.sv
// In-order queue of fetched {inst, pc} entries with flush; head reads as zero when empty.
module fetch_queue
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  logic     i_pop,
  input  logic     i_flush,
  input  q_entry_t i_data,
  output logic     o_full,
  output logic     o_empty,
  output q_entry_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  q_entry_t    r_mem [DEPTH];
  logic [PW:0] r_wr;
  logic [PW:0] r_rd;
  logic        w_pop;
  logic        w_push;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[PW-1:0] == r_rd[PW-1:0]) && (r_wr[PW] != r_rd[PW]);
  assign w_pop   = i_pop && !o_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rd[PW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Fetch controller: holds each address for RD_WAIT extra cycles, samples the memory word
// into the in-order queue, handles branch redirects and stops with a sticky fault on bad addresses.
module imem_fetch_sequencer
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int                RD_WAIT   = 2,
  parameter int                Q_DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = 64'h58
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  imem_fetch_sequencer_if.master io_bus,
  output fetch_state_t          o_state
);

  localparam int CNT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_wait;
  logic              r_fault;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_sample;
  logic [ADDR_W:0]   w_next;
  q_entry_t          w_push_data;
  q_entry_t          w_head;

  assign w_pop       = !w_empty && io_bus.inst_ready;
  assign w_sample    = (r_state != ST_FAULT) && (r_wait == WAIT_MAX) &&
                       (!w_full || w_pop) && !io_bus.redirect_valid;
  assign w_next      = {1'b0, r_pc} + (ADDR_W + 1)'(INST_BYTES);
  assign w_push_data = '{inst: io_bus.imem_data, pc: r_pc};

  fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_sample),
    .i_pop   (w_pop),
    .i_flush (io_bus.redirect_valid),
    .i_data  (w_push_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_ISSUE;
      r_pc    <= RESET_PC;
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else if (io_bus.redirect_valid) begin
      r_pc   <= io_bus.redirect_pc;
      r_wait <= '0;
      if (addr_bad(io_bus.redirect_pc, 1'b0, MEM_LIMIT)) begin
        r_state <= ST_FAULT;
        r_fault <= 1'b1;
      end else begin
        r_state <= ST_ISSUE;
        r_fault <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_ISSUE, ST_WAIT: begin
          if (w_sample) begin
            r_pc   <= w_next[ADDR_W-1:0];
            r_wait <= '0;
            if (addr_bad(w_next[ADDR_W-1:0], w_next[ADDR_W], MEM_LIMIT)) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end else if (r_wait != WAIT_MAX) begin
            // Saturate at WAIT_MAX so a full queue keeps the sample armed.
            r_wait  <= r_wait + CNT_ONE;
            r_state <= ST_WAIT;
          end
        end
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_FAULT;
      endcase
    end
  end

  assign io_bus.imem_addr   = r_pc;
  assign io_bus.inst_valid  = !w_empty;
  assign io_bus.inst        = w_head.inst;
  assign io_bus.inst_pc     = w_head.pc;
  assign io_bus.fetch_fault = r_fault;
  assign o_state            = r_state;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: cycle table for the first fetches, scoreboard for delivery order,
// hand-written sequences for back-pressure, redirects, faults, RD_WAIT=0 and async reset.
module tb_imem_fetch_sequencer;
  import imem_fetch_sequencer_pkg::*;

  typedef struct {
    logic        rdy;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  logic clk = 1'b0;
  logic rst2 = 1'b1;
  logic rst0 = 1'b1;
  fetch_state_t st2, st0;
  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  imem_fetch_sequencer_if bus2();
  imem_fetch_sequencer_if bus0();

  function automatic logic [31:0] rom(input logic [63:0] a);
    case (a)
      64'h00:  return 32'hF84003E9;
      64'h04:  return 32'hF84083EA;
      64'h08:  return 32'hF84103EB;
      64'h34:  return 32'hD29BDE01;
      64'h54:  return 32'hF84283EA;
      default: return 32'hA5000000 | a[31:0];
    endcase
  endfunction

  assign bus2.imem_data = rom(bus2.imem_addr);
  assign bus0.imem_data = rom(bus0.imem_addr);

  imem_fetch_sequencer #(.RD_WAIT(2), .Q_DEPTH(2), .RESET_PC(64'h0), .MEM_LIMIT(64'h58)) dut2 (
    .i_clk(clk), .i_rst(rst2), .io_bus(bus2), .o_state(st2)
  );

  imem_fetch_sequencer #(.RD_WAIT(0), .Q_DEPTH(2), .RESET_PC(64'h0), .MEM_LIMIT(64'h58)) dut0 (
    .i_clk(clk), .i_rst(rst0), .io_bus(bus0), .o_state(st0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard sample for the RD_WAIT=2 instance at the falling edge.
  task automatic sample_edge();
    logic [63:0] e;
    @(negedge clk);
    if (bus2.redirect_valid) begin
      exp_q.delete();
    end else if (bus2.inst_valid && bus2.inst_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got pc %h expected no delivery", bus2.inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus2.inst_pc, e);
        chk("sb_inst", {32'h0, bus2.inst}, {32'h0, rom(e)});
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample_edge();
    advance();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic redirect2(input logic [63:0] pc);
    bus2.redirect_valid = 1'b1;
    bus2.redirect_pc    = pc;
    step();
    bus2.redirect_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.inst_ready     = 1'b1;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = '0;
    bus0.inst_ready     = 1'b0;

    vecs[0] = '{1'b1, 64'h0, 1'b0, 64'h0, 32'h0};
    vecs[1] = '{1'b1, 64'h0, 1'b0, 64'h0, 32'h0};
    vecs[2] = '{1'b1, 64'h0, 1'b0, 64'h0, 32'h0};
    vecs[3] = '{1'b1, 64'h4, 1'b1, 64'h0, 32'hF84003E9};
    vecs[4] = '{1'b1, 64'h4, 1'b0, 64'h0, 32'h0};
    vecs[5] = '{1'b1, 64'h4, 1'b0, 64'h0, 32'h0};
    vecs[6] = '{1'b1, 64'h8, 1'b1, 64'h4, 32'hF84083EA};
    vecs[7] = '{1'b1, 64'h8, 1'b0, 64'h0, 32'h0};

    // Reset state
    @(negedge clk);
    chk("rst_valid", {63'h0, bus2.inst_valid}, 64'h0);
    chk("rst_addr", bus2.imem_addr, 64'h0);
    chk("rst_inst", {32'h0, bus2.inst}, 64'h0);
    chk("rst_pc", bus2.inst_pc, 64'h0);
    chk("rst_fault", {63'h0, bus2.fetch_fault}, 64'h0);
    chk("rst_state", {62'h0, st2}, {62'h0, ST_ISSUE});
    advance();
    rst2 = 1'b0;

    // Test 1: cycle table from reset release
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    for (int i = 0; i < 8; i++) begin
      bus2.inst_ready = vecs[i].rdy;
      sample_edge();
      chk($sformatf("t1_valid_c%0d", i), {63'h0, bus2.inst_valid}, {63'h0, vecs[i].exp_valid});
      chk($sformatf("t1_addr_c%0d", i), bus2.imem_addr, vecs[i].exp_addr);
      chk($sformatf("t1_pc_c%0d", i), bus2.inst_pc, vecs[i].exp_pc);
      chk($sformatf("t1_inst_c%0d", i), {32'h0, bus2.inst}, {32'h0, vecs[i].exp_inst});
      advance();
    end
    chk("t1_sb_empty", 64'(exp_q.size()), 64'h0);

    // Test 2: back-pressure from reset, then ordered release
    rst2 = 1'b1;
    exp_q.delete();
    bus2.inst_ready = 1'b0;
    advance();
    rst2 = 1'b0;
    for (int i = 0; i < 12; i++) step();
    sample_edge();
    chk("t2_valid_held", {63'h0, bus2.inst_valid}, 64'h1);
    chk("t2_head_pc", bus2.inst_pc, 64'h0);
    chk("t2_addr_held", bus2.imem_addr, 64'h8);
    chk("t2_state_wait", {62'h0, st2}, {62'h0, ST_WAIT});
    advance();
    step();
    sample_edge();
    chk("t2_head_stable", bus2.inst_pc, 64'h0);
    advance();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    bus2.inst_ready = 1'b1;
    drain("t2", 30);
    bus2.inst_ready = 1'b0;

    // Test 3: redirect while 0x2C is queued, with a pop in the redirect cycle
    redirect2(64'h2C);
    begin
      int n = 0;
      while (!bus2.inst_valid && n < 10) begin
        step();
        n++;
      end
    end
    chk("t3_head_2c", bus2.inst_pc, 64'h2C);
    bus2.inst_ready = 1'b1;
    redirect2(64'h1C);
    sample_edge();
    chk("t3_flushed", {63'h0, bus2.inst_valid}, 64'h0);
    chk("t3_addr", bus2.imem_addr, 64'h1C);
    advance();
    exp_q.push_back(64'h1C);
    exp_q.push_back(64'h20);
    drain("t3", 30);
    bus2.inst_ready = 1'b0;

    // Test 4: run off the end of the image, then recover
    redirect2(64'h48);
    bus2.inst_ready = 1'b1;
    exp_q.push_back(64'h48);
    exp_q.push_back(64'h4C);
    exp_q.push_back(64'h50);
    exp_q.push_back(64'h54);
    drain("t4", 40);
    for (int i = 0; i < 3; i++) step();
    sample_edge();
    chk("t4_fault", {63'h0, bus2.fetch_fault}, 64'h1);
    chk("t4_addr", bus2.imem_addr, 64'h58);
    chk("t4_no_push", {63'h0, bus2.inst_valid}, 64'h0);
    chk("t4_state", {62'h0, st2}, {62'h0, ST_FAULT});
    advance();
    redirect2(64'h34);
    sample_edge();
    chk("t4_fault_clr", {63'h0, bus2.fetch_fault}, 64'h0);
    advance();
    exp_q.push_back(64'h34);
    drain("t4b", 20);
    bus2.inst_ready = 1'b0;

    // Test 5: misaligned redirect
    redirect2(64'h2);
    sample_edge();
    chk("t5_fault", {63'h0, bus2.fetch_fault}, 64'h1);
    chk("t5_state", {62'h0, st2}, {62'h0, ST_FAULT});
    chk("t5_valid", {63'h0, bus2.inst_valid}, 64'h0);
    advance();
    for (int i = 0; i < 5; i++) step();
    sample_edge();
    chk("t5_no_push", {63'h0, bus2.inst_valid}, 64'h0);
    chk("t5_addr", bus2.imem_addr, 64'h2);
    advance();

    // Test 6: asynchronous reset in WAIT with a full queue
    redirect2(64'h0);
    for (int i = 0; i < 9; i++) step();
    sample_edge();
    chk("t6_pre_state", {62'h0, st2}, {62'h0, ST_WAIT});
    chk("t6_pre_valid", {63'h0, bus2.inst_valid}, 64'h1);
    chk("t6_pre_addr", bus2.imem_addr, 64'h8);
    advance();
    #2;
    rst2 = 1'b1;
    #1;
    chk("t6_async_valid", {63'h0, bus2.inst_valid}, 64'h0);
    chk("t6_async_addr", bus2.imem_addr, 64'h0);
    chk("t6_async_pc", bus2.inst_pc, 64'h0);
    chk("t6_async_state", {62'h0, st2}, {62'h0, ST_ISSUE});
    exp_q.delete();
    advance();
    rst2 = 1'b0;
    bus2.inst_ready = 1'b1;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    drain("t6", 20);
    bus2.inst_ready = 1'b0;

    // RD_WAIT=0 instance: one instruction per cycle, same order
    rst0 = 1'b0;
    bus0.inst_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("r0_addr_c%0d", k), bus0.imem_addr, 64'(4 * k));
      if (k == 0) begin
        chk("r0_valid_c0", {63'h0, bus0.inst_valid}, 64'h0);
      end else begin
        chk($sformatf("r0_valid_c%0d", k), {63'h0, bus0.inst_valid}, 64'h1);
        chk($sformatf("r0_pc_c%0d", k), bus0.inst_pc, 64'(4 * (k - 1)));
        chk($sformatf("r0_inst_c%0d", k), {32'h0, bus0.inst}, {32'h0, rom(64'(4 * (k - 1)))});
      end
      advance();
    end
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 64'h2;
    advance();
    bus0.redirect_valid = 1'b0;
    @(negedge clk);
    chk("r0_fault", {63'h0, bus0.fetch_fault}, 64'h1);
    chk("r0_flushed", {63'h0, bus0.inst_valid}, 64'h0);
    advance();
    @(negedge clk);
    chk("r0_no_push", {63'h0, bus0.inst_valid}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
